// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_conditioner
//  Purpose  : Conditions the raw keypad pins for the simulator top level.
//             Every key channel is synchronised into the clk domain,
//             debounced against the tick_db sampling strobe, and reported as
//             a clean level plus one-cycle press / release / long-press
//             pulses and a sticky hold flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_KEYS    number of independent key channels
//    DB_TICKS    consecutive differing strobes needed to accept a change (>=1)
//    LONG_TICKS  strobes a key must stay high before key_long fires (>=1)
//  Ports
//    clk          system clock
//    rst          synchronous active-high reset (overrides tick_db)
//    tick_db      debounce sampling strobe, one clk wide, may be tied high
//    key_raw      raw active-high key pins
//    key_level    debounced key level
//    key_press    one-clk pulse on an accepted 0->1 change
//    key_release  one-clk pulse on an accepted 1->0 change
//    key_long     one-clk pulse when the hold reaches LONG_TICKS strobes
//    key_hold     high from the key_long pulse until the key is released
//    any_key      OR of key_level (the only combinational output)
// ============================================================================
module key_conditioner #(
    parameter int NUM_KEYS   = 12,
    parameter int DB_TICKS   = 10,
    parameter int LONG_TICKS = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_db,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_hold,
    output logic                any_key
);

    // Counter widths carry one spare bit so that the terminal values
    // (DB_TICKS-1 and LONG_TICKS) are always representable, including the
    // degenerate case of a parameter equal to 1.
    localparam int c_DB_W   = $clog2(DB_TICKS) + 1;
    localparam int c_HOLD_W = $clog2(LONG_TICKS) + 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_TICKS - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_FULL = c_HOLD_W'(LONG_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    // ------------------------------------------------------------------------
    // One fully independent conditioning channel per key.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan

        // Two-flop synchroniser; only r_s2 is allowed into the debouncer.
        logic                r_s1;
        logic                r_s2;

        // Debounce state.
        logic [c_DB_W-1:0]   r_db_cnt;
        logic                r_level;

        // Hold / long-press state. r_hold_cnt saturates at LONG_TICKS so that
        // key_long can fire only once per accepted press.
        logic [c_HOLD_W-1:0] r_hold_cnt;
        logic                r_hold;

        // Registered event pulses.
        logic                r_press;
        logic                r_release;
        logic                r_long;

        logic                w_differs;
        logic                w_accept;
        logic                w_fall;

        // The synchronised sample disagrees with the accepted level.
        assign w_differs = (r_s2 != r_level);

        // This edge completes DB_TICKS consecutive differing strobes, so the
        // new level is taken on this edge.
        assign w_accept  = tick_db && w_differs && (r_db_cnt == c_DB_LAST);

        // Accepted fall: used to drop key_hold on the same edge as key_level
        // rather than one cycle later.
        assign w_fall    = w_accept && r_level;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1       <= 1'b0;
                r_s2       <= 1'b0;
                r_db_cnt   <= '0;
                r_level    <= 1'b0;
                r_hold_cnt <= '0;
                r_hold     <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
            end else begin
                r_s1      <= key_raw[k];
                r_s2      <= r_s1;

                // Pulses are single-cycle unless set again below.
                r_press   <= w_accept && r_s2;
                r_release <= w_fall;
                r_long    <= 1'b0;

                // Debounce: any strobe that sees the accepted level again
                // restarts the run, so short glitches never get through.
                if (tick_db) begin
                    if (!w_differs) begin
                        r_db_cnt <= '0;
                    end else if (w_accept) begin
                        r_level  <= r_s2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_DB_ONE;
                    end
                end

                // Hold tracking works off the level as it stood before this
                // edge, so the strobe that accepts a rise is not counted.
                if (!r_level || w_fall) begin
                    r_hold_cnt <= '0;
                    r_hold     <= 1'b0;
                end else if (tick_db) begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt <= c_HOLD_FULL;
                        r_long     <= 1'b1;
                        r_hold     <= 1'b1;
                    end else if (r_hold_cnt < c_HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                end
            end
        end

        assign key_level[k]   = r_level;
        assign key_press[k]   = r_press;
        assign key_release[k] = r_release;
        assign key_long[k]    = r_long;
        assign key_hold[k]    = r_hold;

    end : g_chan

    assign any_key = |key_level;

endmodule : key_conditioner
`default_nettype wire
